dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the core load/store port (c_*)
//   and a program/data loader port (l_*, used for memory init and debug dumps).
//   Sits between the core datapath and the data RAM: one access at a time,
//   request/grant handshake per port, read data returned to the winning port.
//   Core has priority; a streak counter bounds loader starvation.
// PARAMETERS
//   AW           32  address width
//   DW           32  data width
//   RD_LAT       1   cycles from m_en (read) to valid m_rdata; legal 1..4
//   STARVE_LIMIT 4   consecutive contested core wins before loader forced; >=1
// PORTS
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous, active-low reset
//   c_req     in   1   core request; held stable until c_gnt
//   c_we      in   1   core write (1) / read (0)
//   c_addr    in   AW  core address
//   c_wdata   in   DW  core write data
//   c_gnt     out  1   core request accepted this cycle
//   c_rvalid  out  1   one-cycle pulse, c_rdata valid
//   c_rdata   out  DW  core read data (registered)
//   l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: loader, same as c_*
//   m_en      out  1   memory access strobe
//   m_we      out  1   memory write enable (only with m_en)
//   m_addr    out  AW  memory address; 0 when m_en=0
//   m_wdata   out  DW  memory write data; 0 when m_en=0
//   m_rdata   in   DW  memory read data
//   busy      out  1   read in flight (state WAIT)
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, streak=0, all gnt/rvalid/m_en/m_we/busy=0,
//     c_rdata=l_rdata=0; in-flight read discarded, no rvalid after release.
//   FSM: IDLE, WAIT, RESP.
//   IDLE/RESP: grant allowed. Winner selection (combinational, same cycle):
//     only c_req -> core; only l_req -> loader; both -> core unless
//     streak==STARVE_LIMIT, then loader. x_gnt, m_en, m_we/addr/wdata driven
//     from winner in the grant cycle T.
//   Write grant: completes at T, no rvalid; next state IDLE -> one write/cycle.
//   Read grant: next state WAIT; counter runs RD_LAT cycles (T+1..T+RD_LAT),
//     m_rdata captured into winner's rdata reg at end of T+RD_LAT; state RESP
//     at T+RD_LAT+1 with x_rvalid=1 for exactly that cycle.
//   RESP: rvalid pulse plus a new grant may issue in the same cycle
//     (read-to-read spacing RD_LAT+1). RESP with no grant -> IDLE.
//   WAIT: all gnt=0, m_en=0, busy=1; requests wait.
//   Streak: +1 when core granted while l_req=1; cleared to 0 on loader grant;
//     holds otherwise; saturates at STARVE_LIMIT.
//   rdata regs hold last value until next read for that port; other port's reg
//     never overwritten.
//   Request withdrawn before grant: protocol violation; arbiter latches nothing,
//     so no access is issued for it.
// TESTING
//   1 Reset mid-read: core read granted, rst=0 during WAIT -> no c_rvalid, all
//     outputs 0, state IDLE after release.
//   2 Core read addr 0x10, RAM[0x10]=0xDEADBEEF, RD_LAT=2: c_gnt at T,
//     c_rvalid at T+3, c_rdata=0xDEADBEEF, busy=1 at T+1..T+2.
//   3 Core 3 back-to-back writes 0x0/0x4/0x8: c_gnt and m_we 3 consecutive
//     cycles, no rvalid, l_rdata unchanged.
//   4 c_req,l_req both held (reads), STARVE_LIMIT=4: grants C,C,C,C,L,C... ;
//     l_gnt on 5th grant, streak back to 0.
//   5 Loader read in RESP of core read: c_rvalid and l_gnt same cycle;
//     l_rvalid RD_LAT+1 later with correct data, c_rdata unaffected.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader arbiter for the single-port data memory
// Core wins contested cycles until the streak counter forces one loader grant.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CLAST = CW'(RD_LAT - 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          owner_l;
  logic          pick_c, pick_l, win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    pick_c    = 1'b0;
    pick_l    = 1'b0;
    nxt       = state;
    // Grants are masked during reset so nothing leaks out while rst is low.
    if (rst && state != WAIT) begin
      if (c_req && (!l_req || streak != SLIM)) pick_c = 1'b1;
      else if (l_req)                          pick_l = 1'b1;
    end
    win_we    = pick_l ? l_we    : c_we;
    win_addr  = pick_l ? l_addr  : c_addr;
    win_wdata = pick_l ? l_wdata : c_wdata;
    case (state)
      WAIT:    if (cnt == CLAST) nxt = RESP;
      default: begin
        if ((pick_c || pick_l) && !win_we) nxt = WAIT;
        else                               nxt = IDLE;
      end
    endcase
    c_gnt    = pick_c;
    l_gnt    = pick_l;
    m_en     = pick_c | pick_l;
    m_we     = m_en & win_we;
    m_addr   = m_en ? win_addr  : '0;
    m_wdata  = m_en ? win_wdata : '0;
    busy     = (state == WAIT);
    c_rvalid = (state == RESP) && !owner_l;
    l_rvalid = (state == RESP) &&  owner_l;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      streak  <= '0;
      owner_l <= 1'b0;
      c_rdata <= '0;
      l_rdata <= '0;
    end else begin
      state <= nxt;
      if ((pick_c || pick_l) && !win_we) begin
        owner_l <= pick_l;
        cnt     <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (cnt == CLAST) begin
          if (owner_l) l_rdata <= m_rdata;
          else         c_rdata <= m_rdata;
        end
      end
      if (pick_l)                                streak <= '0;
      else if (pick_c && l_req && streak != SLIM) streak <= streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter (RD_LAT=2, STARVE_LIMIT=4)
// Behavioural RAM with a two-stage read pipeline sits on the m_* port.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [63:0] written;
  logic [31:0] p1, p2;

  function automatic logic [31:0] init_word(input logic [5:0] i);
    case (i)
      6'h04:   return 32'hDEADBEEF;
      6'h08:   return 32'hC0DE0020;
      6'h09:   return 32'h10AD0024;
      6'h0C:   return 32'h11112222;
      6'h0D:   return 32'h33334444;
      default: return {26'h0, i};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) written <= '0;
    else if (m_en && m_we) begin
      mem[m_addr[7:2]]     <= m_wdata;
      written[m_addr[7:2]] <= 1'b1;
    end
    p1 <= written[m_addr[7:2]] ? mem[m_addr[7:2]] : init_word(m_addr[7:2]);
    p2 <= p1;
  end
  assign m_rdata = p2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_l;
  logic       prev_l;

  initial begin
    rst = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_c_rdata", c_rdata, 0);
    check("reset_l_rdata", l_rdata, 0);

    // 1: reset during WAIT discards the read
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    #1;
    check("t1_gnt", c_gnt, 1);
    cyc();
    check("t1_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_gnt", c_gnt, 0);
    check("t1_rst_men", m_en, 0);
    check("t1_rst_maddr", m_addr, 0);
    check("t1_rst_rvalid", c_rvalid, 0);
    c_req = 0;
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t1_no_rvalid", c_rvalid, 0);
      check("t1_idle", busy, 0);
    end

    // 2: core read, RD_LAT=2
    c_req = 1; c_we = 0; c_addr = 32'h10;
    #1;
    check("t2_gnt", c_gnt, 1);
    check("t2_men", m_en, 1);
    check("t2_mwe", m_we, 0);
    check("t2_maddr", m_addr, 32'h10);
    check("t2_busy_T", busy, 0);
    cyc();
    c_req = 0;
    #1;
    check("t2_busy_T1", busy, 1);
    check("t2_men_T1", m_en, 0);
    check("t2_maddr_T1", m_addr, 0);
    cyc();
    check("t2_busy_T2", busy, 1);
    check("t2_rvalid_T2", c_rvalid, 0);
    cyc();
    check("t2_rvalid_T3", c_rvalid, 1);
    check("t2_rdata", c_rdata, 32'hDEADBEEF);
    check("t2_busy_T3", busy, 0);
    cyc();
    check("t2_rvalid_T4", c_rvalid, 0);
    check("t2_rdata_hold", c_rdata, 32'hDEADBEEF);

    // 3: three back-to-back core writes
    for (int i = 0; i < 3; i++) begin
      c_req = 1; c_we = 1; c_addr = 32'(i * 4); c_wdata = 32'hA5A50000 + 32'(i);
      #1;
      check("t3_gnt", c_gnt, 1);
      check("t3_mwe", m_we, 1);
      check("t3_maddr", m_addr, 32'(i * 4));
      check("t3_mwdata", m_wdata, 32'hA5A50000 + 32'(i));
      check("t3_rvalid", c_rvalid | l_rvalid, 0);
      cyc();
    end
    c_req = 0; c_we = 0;
    #1;
    check("t3_busy", busy, 0);
    check("t3_l_rdata", l_rdata, 0);
    check("t3_mem2", mem[2], 32'hA5A50002);

    // 4: both request reads continuously; fifth grant goes to the loader
    exp_l = 6'b010000;
    prev_l = 0;
    c_req = 1; c_we = 0; c_addr = 32'h20;
    l_req = 1; l_we = 0; l_addr = 32'h24;
    #1;
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < 10 && !(c_gnt || l_gnt); w++) cyc();
      check("t4_gnt_l", l_gnt, exp_l[g]);
      check("t4_gnt_c", c_gnt, !exp_l[g]);
      check("t4_maddr", m_addr, exp_l[g] ? 32'h24 : 32'h20);
      if (g > 0) begin
        if (prev_l) begin
          check("t4_l_rvalid", l_rvalid, 1);
          check("t4_l_rdata", l_rdata, 32'h10AD0024);
        end else begin
          check("t4_c_rvalid", c_rvalid, 1);
          check("t4_c_rdata", c_rdata, 32'hC0DE0020);
        end
      end
      prev_l = exp_l[g];
      cyc();
    end
    c_req = 0; l_req = 0;
    cyc(); cyc();
    check("t4_last_rvalid", c_rvalid, 1);
    cyc();

    // 5: loader read granted in the RESP cycle of a core read
    c_req = 1; c_we = 0; c_addr = 32'h30;
    #1;
    check("t5_c_gnt", c_gnt, 1);
    cyc();
    c_req = 0;
    l_req = 1; l_we = 0; l_addr = 32'h34;
    #1;
    check("t5_wait_l_gnt", l_gnt, 0);
    cyc();
    check("t5_wait_l_gnt2", l_gnt, 0);
    cyc();
    check("t5_c_rvalid", c_rvalid, 1);
    check("t5_l_gnt", l_gnt, 1);
    check("t5_c_rdata", c_rdata, 32'h11112222);
    cyc();
    l_req = 0;
    cyc();
    check("t5_l_rvalid_early", l_rvalid, 0);
    cyc();
    check("t5_l_rvalid", l_rvalid, 1);
    check("t5_l_rdata", l_rdata, 32'h33334444);
    check("t5_c_rdata_kept", c_rdata, 32'h11112222);
    cyc();
    check("t5_idle", busy | l_rvalid | c_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
